// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: opcodes, T-state encodings and control word layout for control_sequencer
package control_sequencer_pkg;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
    OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
  } op_e;
  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;
  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_in;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic flags_load;
    logic out_load;
    logic hlt;
    logic last;
  } ctrl_t;
endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// microcode_rom: decodes {step, opcode, flags} into the control word; JC/JZ live only under CONDITIONAL_JUMP_EN
module microcode_rom
  import control_sequencer_pkg::*;
#(
  parameter int STEP_W = 3
) (
  input  logic [STEP_W-1:0] step_i,
  input  logic [3:0]        opcode_i,
  input  logic              flag_carry_i,
  input  logic              flag_zero_i,
  output ctrl_t             ctrl_o
);
  logic t0, t1, t2, t3, t4;
  assign t0 = step_i == STEP_W'(T0);
  assign t1 = step_i == STEP_W'(T1);
  assign t2 = step_i == STEP_W'(T2);
  assign t3 = step_i == STEP_W'(T3);
  assign t4 = step_i == STEP_W'(T4);
`ifndef CONDITIONAL_JUMP_EN
  logic unused_flags;
  assign unused_flags = flag_carry_i ^ flag_zero_i;
`endif
  always_comb begin
    ctrl_o = '0;
    if (t0) begin
      ctrl_o.pc_out = 1'b1;
      ctrl_o.mar_load = 1'b1;
    end else if (t1) begin
      ctrl_o.ram_out = 1'b1;
      ctrl_o.ir_load = 1'b1;
      ctrl_o.pc_inc = 1'b1;
    end else begin
      case (opcode_i)
        OP_LDA: begin
          ctrl_o.ir_out = t2;
          ctrl_o.mar_load = t2;
          ctrl_o.ram_out = t3;
          ctrl_o.a_load = t3;
          ctrl_o.last = t3;
        end
        OP_ADD, OP_SUB: begin
          ctrl_o.ir_out = t2;
          ctrl_o.mar_load = t2;
          ctrl_o.ram_out = t3;
          ctrl_o.b_load = t3;
          ctrl_o.alu_out = t4;
          ctrl_o.a_load = t4;
          ctrl_o.flags_load = t4;
          ctrl_o.alu_sub = t4 && opcode_i == OP_SUB;
          ctrl_o.last = t4;
        end
        OP_STA: begin
          ctrl_o.ir_out = t2;
          ctrl_o.mar_load = t2;
          ctrl_o.a_out = t3;
          ctrl_o.ram_in = t3;
          ctrl_o.last = t3;
        end
        OP_LDI: begin
          ctrl_o.ir_out = t2;
          ctrl_o.a_load = t2;
          ctrl_o.last = t2;
        end
        OP_JMP: begin
          ctrl_o.ir_out = t2;
          ctrl_o.pc_load = t2;
          ctrl_o.last = t2;
        end
`ifdef CONDITIONAL_JUMP_EN
        OP_JC: begin
          ctrl_o.ir_out = t2;
          ctrl_o.pc_load = t2 && flag_carry_i;
          ctrl_o.last = t2;
        end
        OP_JZ: begin
          ctrl_o.ir_out = t2;
          ctrl_o.pc_load = t2 && flag_zero_i;
          ctrl_o.last = t2;
        end
`endif
        OP_OUT: begin
          ctrl_o.a_out = t2;
          ctrl_o.out_load = t2;
          ctrl_o.last = t2;
        end
        OP_HLT: ctrl_o.hlt = t2;
        default: ctrl_o.last = t2;
      endcase
    end
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: T-state counter, halt latch and strobe gating for the 8-bit bus machine.
// Define CONDITIONAL_JUMP_EN to decode JC/JZ; otherwise 0x7/0x8 run as NOP.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  input  logic              flag_carry,
  input  logic              flag_zero,
  output logic              pc_out,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              mar_load,
  output logic              ram_out,
  output logic              ram_in,
  output logic              ir_load,
  output logic              ir_out,
  output logic              a_load,
  output logic              a_out,
  output logic              b_load,
  output logic              alu_out,
  output logic              alu_sub,
  output logic              flags_load,
  output logic              out_load,
  output logic              halt,
  output logic [STEP_W-1:0] tstate
);
  logic [STEP_W-1:0] step_q, step_d;
  logic halted_q, halted_d, en;
  ctrl_t rom_c;
  microcode_rom #(.STEP_W(STEP_W)) u_rom (
    .step_i      (step_q),
    .opcode_i    (opcode),
    .flag_carry_i(flag_carry),
    .flag_zero_i (flag_zero),
    .ctrl_o      (rom_c)
  );
  always_comb begin
    halted_d = halted_q || rom_c.hlt;
    step_d = halted_d ? step_q : rom_c.last ? '0 : step_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q <= step_d;
      halted_q <= halted_d;
    end
  end
  // rst gates strobes combinationally so nothing outlives its assertion
  assign en = !rst && !halted_q;
  assign pc_out = en && rom_c.pc_out;
  assign pc_inc = en && rom_c.pc_inc;
  assign pc_load = en && rom_c.pc_load;
  assign mar_load = en && rom_c.mar_load;
  assign ram_out = en && rom_c.ram_out;
  assign ram_in = en && rom_c.ram_in;
  assign ir_load = en && rom_c.ir_load;
  assign ir_out = en && rom_c.ir_out;
  assign a_load = en && rom_c.a_load;
  assign a_out = en && rom_c.a_out;
  assign b_load = en && rom_c.b_load;
  assign alu_out = en && rom_c.alu_out;
  assign alu_sub = en && rom_c.alu_sub;
  assign flags_load = en && rom_c.flags_load;
  assign out_load = en && rom_c.out_load;
  assign halt = halted_q;
  assign tstate = step_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: self-checking bench with a latency/microprogram-table model of control_sequencer
module tb_control_sequencer;
`ifdef CONDITIONAL_JUMP_EN
  localparam logic CJ = 1'b1;
`else
  localparam logic CJ = 1'b0;
`endif
  localparam logic [14:0] PO = 15'h4000, PI = 15'h2000, PL = 15'h1000, ML = 15'h0800;
  localparam logic [14:0] RO = 15'h0400, RI = 15'h0200, IL = 15'h0100, IO = 15'h0080;
  localparam logic [14:0] AL = 15'h0040, AE = 15'h0020, BL = 15'h0010, XO = 15'h0008;
  localparam logic [14:0] XS = 15'h0004, FL = 15'h0002, OL = 15'h0001;

  logic clk = 1'b0, rst = 1'b1, flag_carry = 1'b0, flag_zero = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load, ir_out;
  logic a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halt;
  logic [2:0] tstate;
  logic [14:0] dut_v;
  int checks = 0, errors = 0;
  int m_step = 0;
  logic m_halted = 1'b0, run = 1'b0;

  control_sequencer #(.STEP_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .flag_carry(flag_carry), .flag_zero(flag_zero),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out(ram_out), .ram_in(ram_in), .ir_load(ir_load), .ir_out(ir_out),
    .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
    .alu_sub(alu_sub), .flags_load(flags_load), .out_load(out_load),
    .halt(halt), .tstate(tstate)
  );

  always #5 clk = ~clk;
  assign dut_v = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load, ir_out,
                  a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load};

  function automatic int lat(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default: return 3;
    endcase
  endfunction

  function automatic logic [14:0] exp_mask(input logic [3:0] op, input int k, input logic c, input logic z);
    if (k == 0) return PO | ML;
    if (k == 1) return RO | IL | PI;
    case (op)
      4'h1: return k == 2 ? IO | ML : RO | AL;
      4'h2, 4'h3: return k == 2 ? IO | ML : k == 3 ? RO | BL : XO | AL | FL | (op == 4'h3 ? XS : 15'h0);
      4'h4: return k == 2 ? IO | ML : AE | RI;
      4'h5: return IO | AL;
      4'h6: return IO | PL;
      4'h7: return CJ ? (IO | (c ? PL : 15'h0)) : 15'h0;
      4'h8: return CJ ? (IO | (z ? PL : 15'h0)) : 15'h0;
      4'hE: return AE | OL;
      default: return 15'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_step <= 0;
      m_halted <= 1'b0;
    end else if (!m_halted) begin
      if (opcode == 4'hF && m_step == 2) m_halted <= 1'b1;
      else m_step <= (m_step + 1 >= lat(opcode)) ? 0 : m_step + 1;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("strobes", 32'(dut_v), 32'((rst || m_halted) ? 15'h0 : exp_mask(opcode, m_step, flag_carry, flag_zero)));
      chk("tstate", 32'(tstate), 32'(m_step));
      chk("halt", 32'(halt), 32'(m_halted && !rst));
      chk("bus", 32'($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1), 32'd1);
    end
  end

  task automatic exec(input logic [3:0] op, input logic c, input logic z, input int n);
    int k;
    opcode = op;
    flag_carry = c;
    flag_zero = z;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tstate !== 3'd0 && k < 8);
    chk("latency", 32'(k), 32'(n));
  endtask

  task automatic addsub(input logic [3:0] op, input logic sub);
    opcode = op;
    repeat (3) @(negedge clk);
    chk("addsub_t3_b_load", 32'(b_load), 32'd1);
    @(negedge clk);
    chk("addsub_t4", 32'({alu_out, a_load, flags_load, alu_sub}), 32'({3'b111, sub}));
    @(negedge clk);
    chk("addsub_wrap", 32'(tstate), 32'd0);
  endtask

  task automatic jump(input logic [3:0] op, input logic c, input logic z, input logic exp_pl);
    opcode = op;
    flag_carry = c;
    flag_zero = z;
    repeat (2) @(negedge clk);
    chk("jump_pc_load", 32'(pc_load), 32'(exp_pl));
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [3:0] op;
    @(posedge clk);
    run = 1'b1;
    @(negedge clk);
    chk("reset_strobes", 32'(dut_v), 32'd0);
    chk("reset_tstate", 32'(tstate), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t0_fetch", 32'(dut_v), 32'(PO | ML));
    @(negedge clk);
    chk("t1_fetch", 32'(dut_v), 32'(RO | IL | PI));
    chk("t1_tstate", 32'(tstate), 32'd1);
    @(negedge clk);
    chk("nop_t2", 32'({tstate, dut_v}), 32'({3'd2, 15'h0}));
    @(negedge clk);
    chk("nop_wrap", 32'(tstate), 32'd0);
    addsub(4'h2, 1'b0);
    addsub(4'h3, 1'b1);
    jump(4'h7, 1'b0, 1'b1, 1'b0);
    jump(4'h7, 1'b1, 1'b0, CJ);
    jump(4'h8, 1'b1, 1'b0, 1'b0);
    jump(4'h8, 1'b0, 1'b1, CJ);
    exec(4'h1, 1'b0, 1'b0, 4);
    exec(4'h4, 1'b0, 1'b0, 4);
    exec(4'h5, 1'b0, 1'b0, 3);
    exec(4'h6, 1'b0, 1'b0, 3);
    exec(4'hE, 1'b0, 1'b0, 3);
    exec(4'hB, 1'b1, 1'b1, 3);
    cyc = 0;
    while (cyc < 1000) begin
      op = 4'($urandom_range(0, 14));
      exec(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lat(op));
      cyc += lat(op);
    end
    opcode = 4'h1;
    repeat (3) @(negedge clk);
    chk("lda_t3", 32'({ram_out, a_load}), 32'd3);
    #1 rst = 1'b1;
    #1 chk("lda_abort", 32'({tstate, ram_out, a_load}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_restart", 32'({tstate, pc_out}), 32'd1);
    opcode = 4'hF;
    repeat (2) @(negedge clk);
    chk("hlt_t2", 32'({halt, dut_v}), 32'd0);
    @(negedge clk);
    chk("halted", 32'({halt, tstate}), 32'({1'b1, 3'd2}));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_frozen", 32'({halt, tstate, dut_v}), 32'({1'b1, 3'd2, 15'h0}));
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("halt_reset", 32'({halt, tstate}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_halt_t0", 32'(dut_v), 32'(PO | ML));
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
